// File: rtl/instr_fetch_dispatch_if.sv
// Instruction-fetch / dispatch bus bundle.
//   imem_rd/imem_addr/imem_ack/imem_data : instruction memory read channel
//   dispatch_addr/dispatch_valid/dispatch_ready : microroutine dispatch handshake
// master = fetch/dispatch unit, slave = memory + sequencer side.
interface instr_fetch_dispatch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;
  logic [5:0]        dispatch_addr;
  logic              dispatch_valid;
  logic              dispatch_ready;

  modport master (
    output imem_rd, imem_addr, dispatch_addr, dispatch_valid,
    input  imem_ack, imem_data, dispatch_ready
  );

  modport slave (
    input  imem_rd, imem_addr, dispatch_addr, dispatch_valid,
    output imem_ack, imem_data, dispatch_ready
  );
endinterface

// File: rtl/instr_fetch_dispatch.sv
// Instruction fetch and dispatch unit, upstream of the microcode sequencer.
// Fetches opcode (and operand byte where needed) from instruction memory,
// maintains the PC, resolves JPNZ on z_flag and hands a 6-bit microroutine
// start address to the sequencer over a valid/ready handshake. The next
// fetch waits for the sequencer's seq_done pulse.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin execution at PC=0 (only honoured in IDLE)
//   z_flag         ALU zero flag, sampled while decoding JPNZ
//   seq_done       sequencer finished the current routine (1-cycle pulse)
//   pc_load(_val)  datapath jump, wins over the fetch increment
//   bus            memory read channel + dispatch handshake (master side)
//   operand        last operand byte fetched (LDAC/STAC/JPNZ)
//   pc             program counter
//   halted         HALT executed
//   illegal        1-cycle pulse on an unknown opcode
module instr_fetch_dispatch #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   z_flag,
  input  logic                   seq_done,
  input  logic                   pc_load,
  input  logic [ADDR_W-1:0]      pc_load_val,
  instr_fetch_dispatch_if.master bus,
  output logic [DATA_W-1:0]      operand,
  output logic [ADDR_W-1:0]      pc,
  output logic                   halted,
  output logic                   illegal
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH_OP  = 3'd1;
  localparam logic [2:0] DECODE    = 3'd2;
  localparam logic [2:0] FETCH_ARG = 3'd3;
  localparam logic [2:0] DISPATCH  = 3'd4;
  localparam logic [2:0] WAIT_DONE = 3'd5;

  localparam logic [5:0] OP_HALT     = 6'd0;
  localparam logic [5:0] OP_JPNZ     = 6'd52;
  localparam logic [5:0] ADDR_JPNZ_Z = 6'd54;
  localparam logic [5:0] ADDR_NOP    = 6'd56;

  logic [2:0] state;
  logic [5:0] opcode;
  logic [5:0] dispatch_addr_q;
  logic       op_known;
  logic       op_has_arg;

  // Opcodes that are microroutine start addresses in their own right.
  always_comb begin
    op_known   = 1'b0;
    op_has_arg = 1'b0;
    case (opcode) inside
      6'd4, 6'd8, OP_JPNZ: begin
        op_known   = 1'b1;
        op_has_arg = 1'b1;
      end
      6'd12, 6'd14, 6'd16, 6'd18, 6'd21, 6'd24, 6'd27, 6'd30, 6'd33,
      [6'd36:6'd51], 6'd55, 6'd56:
        op_known = 1'b1;
      default: ;
    endcase
  end

  assign bus.imem_rd        = (state == FETCH_OP) || (state == FETCH_ARG);
  assign bus.imem_addr      = pc;
  assign bus.dispatch_valid = (state == DISPATCH);
  assign bus.dispatch_addr  = dispatch_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= '0;
      operand         <= '0;
      opcode          <= '0;
      dispatch_addr_q <= '0;
      halted          <= 1'b0;
      illegal         <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc     <= '0;
            halted <= 1'b0;
            state  <= FETCH_OP;
          end
        end
        FETCH_OP: begin
          if (bus.imem_ack) begin
            opcode <= bus.imem_data[5:0];
            pc     <= pc + ADDR_W'(1);
            state  <= DECODE;
          end
        end
        DECODE: begin
          if (opcode == OP_HALT) begin
            halted <= 1'b1;
            state  <= IDLE;
          end else if (!op_known) begin
            illegal         <= 1'b1;
            dispatch_addr_q <= ADDR_NOP;
            state           <= DISPATCH;
          end else begin
            dispatch_addr_q <= (opcode == OP_JPNZ && z_flag) ? ADDR_JPNZ_Z : opcode;
            state           <= op_has_arg ? FETCH_ARG : DISPATCH;
          end
        end
        FETCH_ARG: begin
          if (bus.imem_ack) begin
            operand <= bus.imem_data;
            pc      <= pc + ADDR_W'(1);
            state   <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (bus.dispatch_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (seq_done) state <= FETCH_OP;
        end
        default: state <= IDLE;
      endcase

      // Placed after the state case so a jump overrides the fetch increment.
      if (pc_load && state != IDLE) pc <= pc_load_val;
    end
  end

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// Scoreboard bench for instr_fetch_dispatch: a program-level reference model
// walks randomly generated instruction memory and queues the expected fetch
// addresses and dispatches; a memory responder and a dispatch monitor pop
// and compare independently of the stimulus thread.
module tb_instr_fetch_dispatch;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          z_flag;
  logic          seq_done;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;
  logic [DW-1:0] operand;
  logic [AW-1:0] pc;
  logic          halted;
  logic          illegal;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int ack_cyc = 0;

  instr_fetch_dispatch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch_dispatch #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .z_flag      (z_flag),
    .seq_done    (seq_done),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .bus         (bus.master),
    .operand     (operand),
    .pc          (pc),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [5:0] addr;
    logic [7:0] pc;
    logic [7:0] opnd;
    bit         ill;
    bit         arg;
  } exp_t;

  logic [7:0] mem [256];
  bit         written [256];
  exp_t       exp_q[$];
  logic [7:0] fetch_q[$];
  bit         zarr[$];
  bit         jmp[$];
  logic [7:0] tgt[$];
  bit         zforce[$];
  bit         expect_halt;
  int         nd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected no such event (t=%0t)", name, act, $time);
  endtask

  function automatic bit is_start_addr(input logic [5:0] op);
    return op inside {6'd4, 6'd8, 6'd12, 6'd14, 6'd16, 6'd18, 6'd21, 6'd24, 6'd27,
                      6'd30, 6'd33, [6'd36:6'd51], 6'd55, 6'd56};
  endfunction

  function automatic logic [7:0] rand_opcode();
    int unsigned r = $urandom_range(0, 99);
    logic [1:0]  hi = 2'($urandom_range(0, 3));
    logic [5:0]  o;
    if (r < 10) begin
      do o = 6'($urandom_range(1, 63)); while (is_start_addr(o) || o == 6'd52);
    end else if (r < 25) begin
      o = ($urandom_range(0, 1) != 0) ? 6'd4 : 6'd8;
    end else if (r < 40) begin
      o = 6'd52;
    end else if (r < 97) begin
      do o = 6'($urandom_range(12, 56)); while (!is_start_addr(o));
    end else begin
      o = 6'd0;
    end
    return {hi, o};
  endfunction

  function automatic logic [7:0] read_mem(input logic [7:0] a, input bit as_op);
    if (!written[a]) begin
      written[a] = 1'b1;
      if (as_op) mem[a] = rand_opcode();
      else if ($urandom_range(0, 9) < 3) mem[a] = ($urandom_range(0, 1) != 0) ? 8'hFE : 8'hFF;
      else mem[a] = 8'($urandom);
    end
    return mem[a];
  endfunction

  function automatic void put(input logic [7:0] a, input logic [7:0] d);
    mem[a] = d;
    written[a] = 1'b1;
  endfunction

  // Walk the program as the architecture defines it, recording every fetch
  // address and every expected dispatch.
  function automatic void build(input int n, input bit preset);
    logic [7:0] p = 8'h00;
    logic [7:0] opnd = 8'h00;
    logic [7:0] b;
    logic [5:0] op;
    bit         z;
    exp_t       e;
    if (!preset) foreach (written[i]) written[i] = 1'b0;
    exp_q.delete(); fetch_q.delete(); zarr.delete(); jmp.delete(); tgt.delete();
    expect_halt = 1'b0;
    nd = 0;
    for (int k = 0; k < n; k++) begin
      fetch_q.push_back(p);
      b = read_mem(p, 1'b1);
      p = p + 8'd1;
      op = b[5:0];
      if (op == 6'd0) begin
        expect_halt = 1'b1;
        break;
      end
      z = (zforce.size() > 0) ? zforce.pop_front() : 1'($urandom_range(0, 1));
      e.arg = op inside {6'd4, 6'd8, 6'd52};
      if (e.arg) begin
        fetch_q.push_back(p);
        opnd = read_mem(p, 1'b0);
        p = p + 8'd1;
      end
      if (op == 6'd52)            e.addr = z ? 6'd54 : 6'd52;
      else if (is_start_addr(op)) e.addr = op;
      else                        e.addr = 6'd56;
      e.ill  = !is_start_addr(op) && op != 6'd52;
      e.pc   = p;
      e.opnd = opnd;
      exp_q.push_back(e);
      zarr.push_back(z);
      jmp.push_back(op == 6'd52 && !z);
      tgt.push_back(opnd);
      if (op == 6'd52 && !z) p = opnd;
      nd++;
    end
  endfunction

  // ---------------- memory responder ----------------
  initial begin : responder
    int wait_n = 0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || bus.imem_ack) begin
        bus.imem_ack = 1'b0;
        wait_n = $urandom_range(0, 2);
      end else if (bus.imem_rd) begin
        if (wait_n == 0) begin
          if (fetch_q.size() == 0) fail("fetch_extra", 32'(bus.imem_addr));
          else check("fetch_addr", 32'(bus.imem_addr), 32'(fetch_q.pop_front()));
          bus.imem_data = mem[bus.imem_addr];
          bus.imem_ack  = 1'b1;
          ack_cyc       = cyc;
        end else begin
          wait_n--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        // stray ack with no read outstanding must be ignored
        bus.imem_data = 8'($urandom);
        bus.imem_ack  = 1'b1;
      end
    end
  end

  // ---------------- dispatch monitor ----------------
  initial begin : monitor
    int         ill_cnt = 0;
    bit         prev_v = 1'b0, prev_r = 1'b0, prev_ill = 1'b0;
    logic [5:0] prev_a = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ill_cnt = 0; prev_v = 1'b0; prev_r = 1'b0; prev_ill = 1'b0;
      end else begin
        if (illegal) begin
          ill_cnt++;
          check("illegal_width", 32'(prev_ill), 32'd0);
        end
        if (bus.dispatch_valid && !prev_v && exp_q.size() > 0 && !exp_q[0].arg)
          check("ack_to_valid_latency", 32'(cyc - ack_cyc), 32'd2);
        if (bus.dispatch_valid && prev_v && !prev_r)
          check("addr_stable", 32'(bus.dispatch_addr), 32'(prev_a));
        if (bus.dispatch_valid && bus.dispatch_ready) begin
          if (exp_q.size() == 0) begin
            fail("dispatch_extra", 32'(bus.dispatch_addr));
          end else begin
            e = exp_q.pop_front();
            check("dispatch_addr", 32'(bus.dispatch_addr), 32'(e.addr));
            check("dispatch_pc", 32'(pc), 32'(e.pc));
            check("dispatch_operand", 32'(operand), 32'(e.opnd));
            check("illegal_pulses", 32'(ill_cnt), 32'(e.ill));
          end
          ill_cnt = 0;
        end
        prev_v   = bus.dispatch_valid;
        prev_r   = bus.dispatch_ready;
        prev_ill = illegal;
        prev_a   = bus.dispatch_addr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_operand"}, 32'(operand), 32'd0);
    check({tag, "_dispatch_addr"}, 32'(bus.dispatch_addr), 32'd0);
    check({tag, "_dispatch_valid"}, 32'(bus.dispatch_valid), 32'd0);
    check({tag, "_imem_rd"}, 32'(bus.imem_rd), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; seq_done = 1'b0; pc_load = 1'b0;
    bus.dispatch_ready = 1'b0;
    tick(); tick();
    check_reset("reset");
    rst = 1'b0;
  endtask

  task automatic run_scenario(input int n, input int rst_at, input bit preset, input int hold_first);
    int t;
    int lo;
    build(n, preset);
    do_reset();
    z_flag = (zarr.size() > 0) ? zarr[0] : 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < nd; k++) begin
      t = 0;
      while (!bus.dispatch_valid && t < 100) begin tick(); t++; end
      if (!bus.dispatch_valid) begin
        fail("dispatch_timeout", 32'(k));
        rst = 1'b1; tick(); rst = 1'b0;
        exp_q.delete(); fetch_q.delete();
        return;
      end
      if (k == rst_at) begin
        rst = 1'b1; tick();
        check_reset("rst_in_dispatch");
        rst = 1'b0;
        exp_q.delete(); fetch_q.delete();
        tick(); tick();
        check("idle_after_rst_rd", 32'(bus.imem_rd), 32'd0);
        return;
      end
      lo = (k == 0 && hold_first > 0) ? hold_first : $urandom_range(0, 5);
      repeat (lo) begin
        start    = 1'($urandom_range(0, 1));
        seq_done = 1'($urandom_range(0, 1));
        tick();
      end
      start = 1'b0; seq_done = 1'b0;
      bus.dispatch_ready = 1'b1; tick(); bus.dispatch_ready = 1'b0;
      if (jmp[k]) begin
        repeat ($urandom_range(0, 2)) tick();
        pc_load = 1'b1; pc_load_val = tgt[k]; tick(); pc_load = 1'b0;
      end
      if (k < nd - 1 || expect_halt) begin
        repeat ($urandom_range(0, 3)) tick();
        if (k + 1 < nd) z_flag = zarr[k + 1];
        seq_done = 1'b1; tick(); seq_done = 1'b0;
      end
    end
    if (expect_halt) begin
      t = 0;
      while (!halted && t < 60) begin tick(); t++; end
      check("halted", 32'(halted), 32'd1);
      tick();
      check("halt_imem_rd", 32'(bus.imem_rd), 32'd0);
      check("halt_dispatch_valid", 32'(bus.dispatch_valid), 32'd0);
    end else begin
      repeat (3) tick();
      check("wait_done_imem_rd", 32'(bus.imem_rd), 32'd0);
    end
    check("dispatches_outstanding", 32'(exp_q.size()), 32'd0);
    check("fetches_outstanding", 32'(fetch_q.size()), 32'd0);
  endtask

  initial begin : main
    rst = 1'b1; start = 1'b0; z_flag = 1'b0; seq_done = 1'b0;
    pc_load = 1'b0; pc_load_val = '0; bus.dispatch_ready = 1'b0;

    // Hand-written program: ADD-class op, LDAC with operand, JPNZ not taken,
    // JPNZ taken to 0xFE, illegal op, JPNZ at 0xFF whose operand sits at 0x00
    // (PC wrap), jump to 0x27 which holds HALT.
    foreach (written[i]) written[i] = 1'b0;
    put(8'h00, 8'd39); put(8'h01, 8'd4);  put(8'h02, 8'h5A);
    put(8'h03, 8'd52); put(8'h04, 8'h10); put(8'h05, 8'd52);
    put(8'h06, 8'hFE); put(8'hFE, 8'd63); put(8'hFF, 8'd52);
    put(8'h27, 8'h00);
    zforce = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    run_scenario(20, -1, 1'b1, 5);

    zforce.delete();
    for (int s = 0; s < 30; s++) begin
      run_scenario($urandom_range(4, 40), (s % 5 == 4) ? $urandom_range(0, 3) : -1, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 900000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
